// File: rtl/window_3x3_gen_pkg.sv
// Shared image geometry for the 3x3 window generator and the stages that
// consume its windows (Sobel, median, threshold).
package window_3x3_gen_pkg;

  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;
  localparam int DATA_W = 8;

  // Number of taps in a 3x3 neighbourhood, row-major with the centre at 4
  localparam int TAP_N  = 9;

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bus of the 3x3 window generator.
// master: the pixel source (drives in_*, observes the window side)
// slave : the window generator itself
interface window_3x3_gen_if #(
  parameter int DATA_W = window_3x3_gen_pkg::DATA_W,
  parameter int COL_W  = window_3x3_gen_pkg::COL_W,
  parameter int ROW_W  = window_3x3_gen_pkg::ROW_W
);

  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pix;

  logic              out_valid;
  logic [DATA_W-1:0] s0, s1, s2, s3, s4, s5, s6, s7, s8;
  logic [COL_W-1:0]  out_cx;
  logic [ROW_W-1:0]  out_cy;
  logic              frame_done;

  modport master (
    output in_valid, in_sof, in_pix,
    input  out_valid, s0, s1, s2, s3, s4, s5, s6, s7, s8,
    input  out_cx, out_cy, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pix,
    output out_valid, s0, s1, s2, s3, s4, s5, s6, s7, s8,
    output out_cx, out_cy, frame_done
  );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of storage: single address port, combinational read,
// synchronous write. Contents are never reset; stale data is masked by the
// generator's interior-only emission rule.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the incoming pixel at the current column
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read the same column before it is overwritten, so the old line falls out
  assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Accepts raster-order pixels,
// keeps the two previous lines in line buffers and emits the 3x3 window
// around every interior pixel one cycle after its bottom-right pixel.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_W  = window_3x3_gen_pkg::IMG_W,
  parameter int IMG_H  = window_3x3_gen_pkg::IMG_H,
  parameter int COL_W  = window_3x3_gen_pkg::COL_W,
  parameter int ROW_W  = window_3x3_gen_pkg::ROW_W,
  parameter int DATA_W = window_3x3_gen_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  window_3x3_gen_if.slave  bus
);

  // ---- stage p0: accepted pixel, its coordinates and line-buffer taps ----
  logic              accept;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  x_p0;
  logic [ROW_W-1:0]  y_p0;
  logic              col_last_p0;
  logic              row_last_p0;
  logic              emit_p0;
  logic [DATA_W-1:0] lb0_rd_p0;   // row y-1 at column x
  logic [DATA_W-1:0] lb1_rd_p0;   // row y-2 at column x

  // Two previous columns per window row; the third column is the live tap
  logic [DATA_W-1:0] top_p0 [2];
  logic [DATA_W-1:0] mid_p0 [2];
  logic [DATA_W-1:0] bot_p0 [2];

  // ---- stage p1: registered window ----
  logic              vld_p1;
  logic              done_p1;
  logic [DATA_W-1:0] win_p1 [TAP_N];
  logic [COL_W-1:0]  cx_p1;
  logic [ROW_W-1:0]  cy_p1;

  assign accept = bus.in_valid;

  // in_sof forces the pixel to (0,0) whatever the counters say
  assign x_p0 = bus.in_sof ? '0 : col_q;
  assign y_p0 = bus.in_sof ? '0 : row_q;

  assign col_last_p0 = (x_p0 == COL_W'(IMG_W - 1));
  assign row_last_p0 = (y_p0 == ROW_W'(IMG_H - 1));

  // Only windows whose centre is off the image border are emitted
  assign emit_p0 = accept && (x_p0 >= COL_W'(2)) && (y_p0 >= ROW_W'(2));

  line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (x_p0),
    .wdata (bus.in_pix),
    .rdata (lb0_rd_p0)
  );

  // lb1 receives what lb0 held at this column, i.e. the line before last
  line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x_p0),
    .wdata (lb0_rd_p0),
    .rdata (lb1_rd_p0)
  );

  // Raster counters and the control strobes of the output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= emit_p0;
      done_p1 <= accept && col_last_p0 && row_last_p0;
      if (accept) begin
        if (col_last_p0) begin
          col_q <= '0;
          row_q <= row_last_p0 ? '0 : y_p0 + ROW_W'(1);
        end else begin
          col_q <= x_p0 + COL_W'(1);
          row_q <= y_p0;
        end
      end
    end
  end

  // Column history: shifts on every accepted pixel, including row starts;
  // columns carried over from the previous row are never emitted
  always_ff @(posedge clk) begin
    if (accept) begin
      top_p0[0] <= top_p0[1];
      top_p0[1] <= lb1_rd_p0;
      mid_p0[0] <= mid_p0[1];
      mid_p0[1] <= lb0_rd_p0;
      bot_p0[0] <= bot_p0[1];
      bot_p0[1] <= bus.in_pix;
    end
  end

  // ---- stage p0 -> p1: capture the window; hold it between emissions ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAP_N; i++) begin
        win_p1[i] <= '0;
      end
      cx_p1 <= '0;
      cy_p1 <= '0;
    end else if (emit_p0) begin
      win_p1[0] <= top_p0[0];
      win_p1[1] <= top_p0[1];
      win_p1[2] <= lb1_rd_p0;
      win_p1[3] <= mid_p0[0];
      win_p1[4] <= mid_p0[1];
      win_p1[5] <= lb0_rd_p0;
      win_p1[6] <= bot_p0[0];
      win_p1[7] <= bot_p0[1];
      win_p1[8] <= bus.in_pix;
      cx_p1     <= x_p0 - COL_W'(1);
      cy_p1     <= y_p0 - ROW_W'(1);
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.frame_done = done_p1;
  assign bus.out_cx     = cx_p1;
  assign bus.out_cy     = cy_p1;
  assign bus.s0         = win_p1[0];
  assign bus.s1         = win_p1[1];
  assign bus.s2         = win_p1[2];
  assign bus.s3         = win_p1[3];
  assign bus.s4         = win_p1[4];
  assign bus.s5         = win_p1[5];
  assign bus.s6         = win_p1[6];
  assign bus.s7         = win_p1[7];
  assign bus.s8         = win_p1[8];

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
Streaming 3x3 neighbourhood generator. It sits directly upstream of the Sobel gradient stage and the salt-and-pepper median stage. It accepts one 8-bit grayscale pixel per valid cycle in raster order, buffers the two previous image rows, and presents the nine window taps s0..s8 (row-major, s4 = centre) together with a valid strobe. It emits only interior windows, i.e. windows whose centre is not on the image border.

Parameters:
IMG_W, 640, image width in pixels (>= 3)
IMG_H, 480, image height in lines (>= 3)
COL_W, 10, width of the column counter (must satisfy 2^COL_W >= IMG_W)
ROW_W, 9, width of the row counter (must satisfy 2^ROW_W >= IMG_H)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_pix is valid this cycle
in_sof  in  1  qualifies in_valid; marks pixel (0,0) of a new frame
in_pix  in  8  grayscale pixel
out_valid  out  1  s0..s8 hold a valid window this cycle
s0..s8  out  8 each  window taps: s0..s2 top row, s3..s5 middle row, s6..s8 bottom row, left to right
out_cx  out  COL_W  column of window centre
out_cy  out  ROW_W  row of window centre
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: out_valid=0, frame_done=0, s0..s8=0, out_cx=0, out_cy=0, col=0, row=0. Line-buffer contents are don't-care. Reset asserted mid-frame aborts the frame; the next accepted pixel is treated as (0,0) whether or not in_sof is set.
- Counters: col and row advance only on in_valid. col wraps at IMG_W-1 to 0 and row increments. After (IMG_W-1, IMG_H-1), both wrap to 0 and frame_done pulses on the next cycle.
- in_sof with in_valid: the pixel is forced to (0,0) regardless of counter state, so a mid-frame resync restarts counting. No window is emitted for rows 0..1 of the restarted frame.
- Line buffers: two IMG_W x 8 buffers, lb0 (row y-1) and lb1 (row y-2), indexed by col with combinational read. On each accepted pixel, in the same cycle: read lb0[col] and lb1[col], write lb1[col]<=lb0[col] and lb0[col]<=in_pix.
- Window shift: three 3-deep column shift registers. Top row is fed from lb1, middle row from lb0, bottom row from in_pix. They shift only on accepted pixels. Columns shifted in during the previous row carry over; they are never emitted because of the col>=2 rule.
- Emission: when pixel (x,y) is accepted with x>=2 and y>=2, the next cycle has out_valid=1 and:
  - s0=P(x-2,y-2), s1=P(x-1,y-2), s2=P(x,y-2)
  - s3=P(x-2,y-1), s4=P(x-1,y-1), s5=P(x,y-1)
  - s6=P(x-2,y), s7=P(x-1,y), s8=P(x,y)
  - out_cx=x-1, out_cy=y-1
- Latency is 1 cycle from the accepted pixel to its window. There are no output stalls; downstream must accept every out_valid.
- The outputs s*, out_cx and out_cy hold their values when out_valid=0. out_valid is 0 on idle cycles and for x<2 or y<2.
- Each frame produces exactly (IMG_W-2)*(IMG_H-2) windows.
- Bubbles (in_valid=0) between any two pixels, including across row ends, do not change the windows produced.

Decomposition:
- Shared package/header holds the constants IMG_W, IMG_H, COL_W and ROW_W, so the Sobel, median and threshold stages agree on image geometry.
- One sub-module: line_buffer, a single-port IMG_W x 8 memory with combinational read and synchronous write enable. It is instantiated twice.

Test Plan:
- IMG_W=4, IMG_H=4, pixel value 16*y+x, continuous in_valid with in_sof on the first pixel → 4 windows. First window: s0..s8 = 00,01,02,10,11,12,20,21,22 with cx=1,cy=1, one cycle after pixel 0x22. Last window: s4=0x22, s8=0x33. frame_done pulses once.
- Same frame with random in_valid gaps (0-3 idle cycles) → windows identical to the continuous case and in the same order; out_valid never asserts on gap cycles.
- Two back-to-back frames where frame 2 pixel = frame 1 pixel + 0x80 → frame 2's first window s0=0x80 and s8=0xA2, with no frame 1 data in any tap.
- in_sof asserted at pixel index 9 of a 4x4 frame, then 16 pixels → exactly 4 windows, all referencing post-resync data; frame_done pulses only after the resynced frame completes.
- rst asserted for 1 cycle after 7 pixels, then a full 4x4 frame without in_sof → all outputs are zero during reset; the frame yields 4 correct windows.
- IMG_W=640, IMG_H=480, random pixels checked against a software 3x3 model → 638*478 = 304964 windows, all matching, with a single frame_done.
